// File: rtl/instr_encoder_if.sv
// ----------------------------------------------------------------------------
// instr_encoder_if
//
// Bundles the producer-side field inputs and the consumer-side FIFO outputs
// of instr_encoder. Clock and reset stay as plain module ports.
//
//   in_valid / in_ready   push handshake (producer -> encoder)
//   in_fmt .. in_imm      decoded instruction fields
//   out_valid / out_ready pop handshake (encoder -> consumer)
//   out_instr / out_err   FIFO head entry
//   out_count             FIFO occupancy
//
// Modports:
//   slave  - the encoder itself
//   master - the environment driving fields and consuming results
// ----------------------------------------------------------------------------
interface instr_encoder_if #(
   parameter int unsigned FIFO_DEPTH = 2
);
   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_fmt;
   logic [6:0]      in_opcode;
   logic [4:0]      in_rd;
   logic [4:0]      in_rs1;
   logic [4:0]      in_rs2;
   logic [2:0]      in_funct3;
   logic [6:0]      in_funct7;
   logic [31:0]     in_imm;
   logic            out_valid;
   logic            out_ready;
   logic [31:0]     out_instr;
   logic            out_err;
   logic [CntW-1:0] out_count;

   modport slave (
      input  in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      output in_ready,
      output out_valid, out_instr, out_err, out_count,
      input  out_ready
   );

   modport master (
      output in_valid, in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm,
      input  in_ready,
      input  out_valid, out_instr, out_err, out_count,
      output out_ready
   );
endinterface

// File: rtl/instr_encoder.sv
// ----------------------------------------------------------------------------
// instr_encoder
//
// RV32I instruction encoder (inverse of the immediate generator). Decoded
// fields plus a full 32-bit immediate are packed combinationally into an
// instruction word; the word and an "immediate not representable" flag are
// then written into a small output FIFO.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (deassertion synchronised upstream)
//   bus    instr_encoder_if.slave
//            in_*  : push side, in_ready = !full (registered occupancy only)
//            out_* : pop side, head entry, occupancy
//
// Parameters:
//   FIFO_DEPTH  output FIFO entries; power of two, >= 2
// ----------------------------------------------------------------------------
module instr_encoder #(
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   instr_encoder_if.slave  bus
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   typedef enum logic [2:0] {
      FmtR = 3'd0,
      FmtI = 3'd1,
      FmtS = 3'd2,
      FmtB = 3'd3,
      FmtU = 3'd4,
      FmtJ = 3'd5
   } fmt_e;

   typedef struct packed {
      logic        err;
      logic [31:0] instr;
   } entry_t;

   // ---------------------------------------------------------------------
   // Immediate range checks
   // ---------------------------------------------------------------------
   logic signed [31:0] imm_s;
   logic               fits_12;
   logic               fits_b;
   logic               fits_j;
   logic               fits_u;

   assign imm_s = $signed(bus.in_imm);

   // Signed compares are equivalent to "upper bits are a sign extension".
   assign fits_12 = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
   // Branch and jump offsets are halfword multiples; bit 0 is never encoded.
   assign fits_b  = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !bus.in_imm[0];
   assign fits_j  = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !bus.in_imm[0];
   assign fits_u  = (bus.in_imm[11:0] == 12'h000);

   // ---------------------------------------------------------------------
   // Combinational encoder
   // ---------------------------------------------------------------------
   logic [31:0] enc_instr;
   logic        enc_err;
   logic [31:0] imm;

   assign imm = bus.in_imm;

   always_comb begin
      enc_instr = 32'h0000_0000;
      enc_err   = 1'b0;
      unique case (fmt_e'(bus.in_fmt))
         FmtR: begin
            enc_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd,
                         bus.in_opcode};
         end
         FmtI: begin
            enc_instr = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
            enc_err   = !fits_12;
         end
         FmtS: begin
            enc_instr = {imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:0],
                         bus.in_opcode};
            enc_err   = !fits_12;
         end
         FmtB: begin
            enc_instr = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, imm[4:1],
                         imm[11], bus.in_opcode};
            enc_err   = !fits_b;
         end
         FmtU: begin
            enc_instr = {imm[31:12], bus.in_rd, bus.in_opcode};
            enc_err   = !fits_u;
         end
         FmtJ: begin
            enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, bus.in_opcode};
            enc_err   = !fits_j;
         end
         default: begin
            // Illegal format codes 6/7 produce an all-zero word flagged as error.
            enc_instr = 32'h0000_0000;
            enc_err   = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Output FIFO
   // ---------------------------------------------------------------------
   entry_t          mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;
   entry_t          wr_entry;

   assign full  = (count_q == CntW'(FIFO_DEPTH));
   assign empty = (count_q == '0);

   // No full-bypass: a full FIFO refuses a push even if a pop happens now.
   assign push  = bus.in_valid && !full;
   assign pop   = !empty && bus.out_ready;

   assign wr_entry = '{err: enc_err, instr: enc_instr};

   // Pointers wrap naturally because the depth is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is cleared on reset so the head reads as zero out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push) begin
         mem_q[wr_ptr_q] <= wr_entry;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign bus.in_ready  = !full;
   assign bus.out_valid = !empty;
   assign bus.out_instr = mem_q[rd_ptr_q].instr;
   assign bus.out_err   = mem_q[rd_ptr_q].err;
   assign bus.out_count = count_q;

`ifndef SYNTHESIS
   count_in_range_a : assert property (@(posedge clk) disable iff (!rst_n)
      count_q <= CntW'(FIFO_DEPTH));
   no_push_when_full_a : assert property (@(posedge clk) disable iff (!rst_n)
      full |-> !push);
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// ----------------------------------------------------------------------------
// tb_instr_encoder
//
// Self-checking bench for instr_encoder (FIFO_DEPTH = 2). A queue holds the
// expected FIFO contents; expected words come from a reference encoder that
// works on the immediate as a plain integer.
// ----------------------------------------------------------------------------
module tb_instr_encoder;

   localparam int unsigned Depth = 2;

   logic clk;
   logic rst_n;

   instr_encoder_if #(.FIFO_DEPTH(Depth)) bus ();

   instr_encoder #(.FIFO_DEPTH(Depth)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_cmp;
   int unsigned n_bad;
   logic [32:0] exp_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: returns {err, word}.
   function automatic logic [32:0] ref_enc(input logic [2:0] fmt, input logic [6:0] op,
                                           input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [4:0] rs2, input logic [2:0] f3,
                                           input logic [6:0] f7, input logic [31:0] imm);
      int          v;
      logic [31:0] w;
      logic        e;
      v = $signed(imm);
      w = 32'h0;
      e = 1'b0;
      case (fmt)
         3'd0: w = {f7, rs2, rs1, f3, rd, op};
         3'd1: begin
            w = {imm[11:0], rs1, f3, rd, op};
            e = (v < -2048) || (v > 2047);
         end
         3'd2: begin
            w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
            e = (v < -2048) || (v > 2047);
         end
         3'd3: begin
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
            e = (v < -4096) || (v > 4094) || (v % 2 != 0);
         end
         3'd4: begin
            w = {imm[31:12], rd, op};
            e = (imm % 4096) != 0;
         end
         3'd5: begin
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
            e = (v < -1048576) || (v > 1048574) || (v % 2 != 0);
         end
         default: begin
            w = 32'h0;
            e = 1'b1;
         end
      endcase
      return {e, w};
   endfunction

   task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
      bus.in_fmt    = fmt;
      bus.in_opcode = op;
      bus.in_rd     = rd;
      bus.in_rs1    = rs1;
      bus.in_rs2    = rs2;
      bus.in_funct3 = f3;
      bus.in_funct7 = f7;
      bus.in_imm    = imm;
   endtask

   task automatic verify(input string ctx);
      check_val({ctx, ".count"}, 32'(bus.out_count), 32'(exp_q.size()));
      check_val({ctx, ".in_ready"}, 32'(bus.in_ready), 32'(exp_q.size() < Depth));
      check_val({ctx, ".out_valid"}, 32'(bus.out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         check_val({ctx, ".instr"}, bus.out_instr, exp_q[0][31:0]);
         check_val({ctx, ".err"}, 32'(bus.out_err), 32'(exp_q[0][32]));
      end
   endtask

   // One clock: drive handshakes with the fields already set, advance, update model, check.
   task automatic step(input logic v, input logic ordy, input string ctx);
      bit          do_push;
      bit          do_pop;
      logic [32:0] e;
      bus.in_valid  = v;
      bus.out_ready = ordy;
      do_push = v && (exp_q.size() < Depth);
      do_pop  = ordy && (exp_q.size() != 0);
      e = ref_enc(bus.in_fmt, bus.in_opcode, bus.in_rd, bus.in_rs1, bus.in_rs2, bus.in_funct3,
                  bus.in_funct7, bus.in_imm);
      @(posedge clk);
      #1;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back(e);
      verify(ctx);
   endtask

   // Push one instruction into an empty FIFO and compare against a hand-computed word.
   task automatic directed(input string tag, input logic [2:0] fmt, input logic [6:0] op,
                           input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [2:0] f3, input logic [31:0] imm,
                           input logic [31:0] exp_w, input logic exp_e);
      set_fields(fmt, op, rd, rs1, rs2, f3, 7'h00, imm);
      step(1'b1, 1'b0, tag);
      check_val({tag, ".word"}, bus.out_instr, exp_w);
      check_val({tag, ".flag"}, 32'(bus.out_err), 32'(exp_e));
      step(1'b0, 1'b1, {tag, ".drain"});
   endtask

   function automatic logic [31:0] rand_imm();
      int bnd[12] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4098,
                      1048574, 1048576, -1048576, -1048578};
      int r;
      case ($urandom_range(0, 5))
         0: return $urandom;
         1: begin
            r = int'($urandom_range(0, 4200));
            return ($urandom_range(0, 1) != 0) ? 32'(-r) : 32'(r);
         end
         2: return 32'(bnd[$urandom_range(0, 11)]);
         3: return 32'(int'($urandom_range(0, 2100000)) - 1050000);
         4: return $urandom & 32'hFFFF_F000;
         default: return 32'(int'($urandom_range(0, 64)) - 32);
      endcase
   endfunction

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      set_fields(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h0);

      // Reset state
      #3;
      check_val("rst.out_valid", 32'(bus.out_valid), 32'd0);
      check_val("rst.out_count", 32'(bus.out_count), 32'd0);
      check_val("rst.in_ready", 32'(bus.in_ready), 32'd1);
      check_val("rst.out_instr", bus.out_instr, 32'h0);
      check_val("rst.out_err", 32'(bus.out_err), 32'd0);
      #9;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed encodings
      directed("i_addi", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0050_0093, 1'b0);
      directed("s_sw", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd8, 32'h0020_A423, 1'b0);
      directed("b_neg", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 32'hFE00_0EE3, 1'b0);
      directed("u_lui", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000, 32'h1234_52B7,
               1'b0);
      directed("j_jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h0010_00EF, 1'b0);
      directed("i_ovf", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, 1'b1);
      directed("b_even", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd6, 32'h0000_0363, 1'b0);
      directed("b_odd", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd5, 32'h0000_0263, 1'b1);
      directed("u_low", 3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5001, 32'h1234_52B7,
               1'b1);
      directed("fmt7", 3'd7, 7'h13, 5'd3, 5'd4, 5'd5, 3'd1, 32'd1, 32'h0000_0000, 1'b1);

      // Backpressure: three back-to-back pushes with out_ready low
      set_fields(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1);
      step(1'b1, 1'b0, "bp.push0");
      set_fields(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2);
      step(1'b1, 1'b0, "bp.push1");
      check_val("bp.full_ready", 32'(bus.in_ready), 32'd0);
      check_val("bp.full_count", 32'(bus.out_count), 32'd2);
      set_fields(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3);
      step(1'b1, 1'b0, "bp.blocked");
      step(1'b1, 1'b1, "bp.pop0");
      check_val("bp.ready_after_pop", 32'(bus.in_ready), 32'd1);
      step(1'b1, 1'b1, "bp.push2");
      step(1'b0, 1'b1, "bp.pop2");
      step(1'b0, 1'b1, "bp.pop3");

      // Reset mid-stream with the FIFO full
      set_fields(3'd0, 7'h33, 5'd7, 5'd8, 5'd9, 3'd0, 7'h20, 32'h0);
      step(1'b1, 1'b0, "mr.fill0");
      step(1'b1, 1'b0, "mr.fill1");
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check_val("mr.out_valid", 32'(bus.out_valid), 32'd0);
      check_val("mr.out_count", 32'(bus.out_count), 32'd0);
      check_val("mr.in_ready", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      check_val("mr.push_ignored", 32'(bus.out_count), 32'd0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      verify("mr.released");
      set_fields(3'd1, 7'h13, 5'd9, 5'd1, 5'd0, 3'd0, 7'h00, 32'd100);
      step(1'b1, 1'b0, "mr.first");
      step(1'b0, 1'b0, "mr.alone");
      step(1'b0, 1'b1, "mr.drain");

      // Randomised traffic
      for (int i = 0; i < 600; i++) begin
         set_fields(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                    5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0), "rnd");
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 1'b1, "rnd.drain");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Pipelined RV32I instruction encoder, the inverse of the core's immediate generator. It accepts decoded instruction fields plus a full 32-bit immediate value and packs them into a 32-bit instruction word, scattering the immediate bits per format. It flags immediates that the format cannot represent. Results are buffered in a small output FIFO with valid/ready handshakes on both sides, so the block can sit between the test-program builder / boot loader and instruction memory.

## Interface

Parameters:
- FIFO_DEPTH, 2: output FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input fields valid.
- in_ready  output  1  block can accept; equals !full.
- in_fmt  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- in_opcode  input  7  placed verbatim in [6:0].
- in_rd  input  5  destination register; used by R/I/U/J.
- in_rs1  input  5  used by R/I/S/B.
- in_rs2  input  5  used by R/S/B.
- in_funct3  input  3  used by R/I/S/B.
- in_funct7  input  7  used by R only.
- in_imm  input  32  signed byte value (B/J offset), or the full 32-bit upper value (U).
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head entry.
- out_instr  output  32  encoded instruction at FIFO head.
- out_err  output  1  head entry's immediate was not representable.
- out_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation

- Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
- Encoding is combinational from the inputs. The word and its err bit are written into the FIFO on push.
- Field placement:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Error rules. The word is still encoded from the truncated bits when err=1.
  - I/S: err when imm is outside [-2048, 2047].
  - B: err when imm is outside [-4096, 4094] or imm[0]=1.
  - J: err when imm is outside [-1048576, 1048574] or imm[0]=1.
  - U: err when imm[11:0]≠0.
  - R: imm ignored; err=0.
  - fmt 6/7: word=32'h0000_0000, err=1.
- Range checks use a signed 32-bit compare (sign-extension check of the upper bits).
- The FIFO is in-order with no drops and no reordering.
- Full: in_ready=0, and no push occurs even if out_ready=1 in the same cycle. There is no full-bypass.
- Push and pop in the same cycle when not full: occupancy is unchanged and both operations succeed.
- Pointers wrap modulo FIFO_DEPTH.
- Empty: out_valid=0. out_instr/out_err then hold the last-read RAM slot and are don't-care.

## Timing

- Latency: a push in cycle N makes the entry visible with out_valid=1 in cycle N+1 at the earliest. There is no same-cycle combinational path from in_* to out_*.
- in_ready depends only on registered occupancy. It has no combinational dependency on out_ready.
- Throughput: one instruction per cycle when out_ready is held high.
- Reset (rst_n low, asynchronous):
  - Pointers and count clear.
  - out_valid=0, out_count=0, out_instr=0, out_err=0.
  - in_ready=1.
  - Pushes are ignored while rst_n is low.
- Reset mid-operation: all buffered entries are discarded immediately. The first push after release reappears at N+1.
- Deassertion of rst_n is synchronized externally; the block does not resynchronize it.

## Test plan

- I-type: fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=5 -> next cycle out_valid=1, out_instr=0x00500093, out_err=0.
- S and B encoding:
  - fmt=2, op=0x23, rs1=1, rs2=2, f3=2, imm=8 -> 0x0020A423.
  - fmt=3, op=0x63, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3.
- U and J encoding:
  - fmt=4, op=0x37, rd=5, imm=0x12345000 -> 0x123452B7.
  - fmt=5, op=0x6F, rd=1, imm=2048 -> 0x001000EF.
- Errors:
  - I imm=2048 -> out_err=1, out_instr=0x80000093.
  - B imm=6 -> err=0; B imm=5 -> err=1.
  - U imm=0x12345001 -> err=1.
  - fmt=7 -> 0x00000000 with err=1.
- Backpressure (FIFO_DEPTH=2), out_ready=0, three back-to-back pushes:
  - in_ready drops after two pushes; out_count=2.
  - Raise out_ready: outputs appear in order, one per cycle.
  - The third push is accepted the cycle after the first pop.
- Reset mid-stream: with out_count=2, pulse rst_n low -> out_valid=0, out_count=0, in_ready=1 immediately. The next push appears alone at N+1.
